// File: rtl/lut_input_sequencer.sv
// Stimulus sequencer for the 8-bit LUT mapping block: a writable entry table
// streamed in order over a valid/ready port, one entry per transfer.
module lut_input_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_count,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_index
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_n, w_n_nx;
  logic [ADDR_W-1:0] r_index, w_index_nx;
  logic [DATA_W-1:0] r_out_data, w_out_data_nx;
  logic              r_out_valid, w_out_valid_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;

  logic              w_wr_ok;
  logic              w_xfer;
  logic              w_last;
  logic [ADDR_W-1:0] w_clip_n;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_wr_ok   = i_wr_en && (i_wr_addr < DEPTH_A);
  assign w_xfer    = r_out_valid && i_out_ready;
  assign w_last    = (r_index == (r_n - ADDR_W'(1)));
  assign w_clip_n  = (i_count > DEPTH_A) ? DEPTH_A : i_count;

  // Next entry to present; a same-cycle write to it is forwarded so it lands.
  assign w_rd_addr = (r_state == S_IDLE) ? '0 : (r_index + ADDR_W'(1));
  assign w_rd_data = (w_wr_ok && (i_wr_addr == w_rd_addr)) ? i_wr_data : r_mem[w_rd_addr];

  // Table storage survives reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_index     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_n         <= w_n_nx;
      r_index     <= w_index_nx;
      r_out_data  <= w_out_data_nx;
      r_out_valid <= w_out_valid_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_n_nx         = r_n;
    w_index_nx     = r_index;
    w_out_data_nx  = r_out_data;
    w_out_valid_nx = r_out_valid;
    w_busy_nx      = r_busy;
    w_done_nx      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_n_nx     = w_clip_n;
          w_index_nx = '0;
          if (w_clip_n == '0) begin
            w_state_nx = S_FIN;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx     = S_PLAY;
            w_out_valid_nx = 1'b1;
            w_out_data_nx  = w_rd_data;
            w_busy_nx      = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_nx     = S_FIN;
            w_out_valid_nx = 1'b0;
            w_busy_nx      = 1'b0;
            w_done_nx      = 1'b1;
          end else begin
            w_index_nx    = r_index + ADDR_W'(1);
            w_out_data_nx = w_rd_data;
          end
        end
      end
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_index     = r_index;

endmodule

// File: tb/tb_lut_input_sequencer.sv
// Bench for lut_input_sequencer: table-and-queue reference model, randomized
// ready/write/start stimulus, one task per scenario.
module tb_lut_input_sequencer;
  localparam int DEPTH = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_wr_en;
  logic [4:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       i_start;
  logic [4:0] i_count;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       i_out_ready;
  logic       o_busy;
  logic       o_done;
  logic [4:0] o_index;

  lut_input_sequencer #(.DATA_W(8), .DEPTH(20), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_count(i_count),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done), .o_index(o_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] tbl [DEPTH];
  logic [7:0] exp_q [$];
  logic [7:0] q_data [$];
  int         q_idx [$];
  int         n_busy, done_gap, hold_err;
  bit         done_seen, done_after, busy_after;

  bit         sw_en, mw_en, start_spam;
  int         sw_addr, mw_addr, stall_idx, abort_after;
  logic [7:0] sw_data, mw_data;
  logic       ab_valid, ab_busy, ab_done;
  logic [4:0] ab_index;
  logic [7:0] ab_data;

  task automatic clear_opts();
    sw_en = 0; mw_en = 0; start_spam = 0; sw_addr = 0; mw_addr = 0;
    sw_data = '0; mw_data = '0; stall_idx = -1; abort_after = 0;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    i_wr_en = 1'b1; i_wr_addr = 5'(addr); i_wr_data = data;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    if (addr < DEPTH) tbl[addr] = data;
  endtask

  task automatic snap_exp(input int cnt);
    int n;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(tbl[i]);
  endtask

  // Drives one start and observes the run up to done (bounded); results land in q_*.
  task automatic play(input int cnt, input int rdy_pct);
    int last_cyc, stall_cnt;
    bit hold_p, rdy;
    logic [7:0] pd;
    logic [4:0] pi;
    q_data.delete(); q_idx.delete();
    n_busy = 0; done_gap = -1; hold_err = 0;
    done_seen = 0; done_after = 0; busy_after = 0;
    last_cyc = -1; stall_cnt = 0; hold_p = 0; pd = '0; pi = '0;
    i_start = 1'b1; i_count = 5'(cnt);
    i_wr_en = sw_en; i_wr_addr = 5'(sw_addr); i_wr_data = sw_data;
    if (sw_en && sw_addr < DEPTH) tbl[sw_addr] = sw_data;
    @(posedge clk); #1;
    i_start = 1'b0; i_wr_en = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (o_done) begin
        done_seen = 1; done_gap = cyc - last_cyc;
        i_start = start_spam; i_count = '0; i_out_ready = 1'b0;
        @(posedge clk); #1;
        done_after = o_done; busy_after = o_busy; i_start = 1'b0;
        break;
      end
      if (o_busy) n_busy++;
      if (hold_p && (o_out_data !== pd || o_index !== pi || o_out_valid !== 1'b1)) hold_err++;
      rdy = ($urandom_range(99) < rdy_pct);
      if (stall_idx >= 0 && o_out_valid && int'(o_index) == stall_idx && stall_cnt < 4) begin
        rdy = 0; stall_cnt++;
      end
      i_out_ready = rdy;
      i_start = start_spam; i_count = 5'($urandom_range(31));
      if (mw_en && cyc == 0) begin
        i_wr_en = 1'b1; i_wr_addr = 5'(mw_addr); i_wr_data = mw_data;
        if (mw_addr < DEPTH) tbl[mw_addr] = mw_data;
      end else i_wr_en = 1'b0;
      hold_p = o_out_valid && !rdy; pd = o_out_data; pi = o_index;
      if (o_out_valid && rdy) begin
        q_data.push_back(o_out_data); q_idx.push_back(int'(o_index)); last_cyc = cyc;
      end
      @(posedge clk); #1;
      if (abort_after > 0 && q_data.size() == abort_after) begin
        rst = 1'b1; #1;
        ab_valid = o_out_valid; ab_busy = o_busy; ab_done = o_done;
        ab_index = o_index; ab_data = o_out_data;
        break;
      end
    end
    i_start = 1'b0; i_wr_en = 1'b0; i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_wr_en = 0; i_wr_addr = '0; i_wr_data = '0;
    i_start = 0; i_count = '0; i_out_ready = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_out_valid); end
    total++; if (o_out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", o_out_data); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    total++; if (o_index !== 5'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", o_index); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL idle_quiet got=%b%b exp=00", o_out_valid, o_done);
    end
  endtask

  task automatic check_run(input string tag);
    total++; if (q_data.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, q_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q_data.size(); i++) begin
      total++; if (q_data[i] !== exp_q[i] || q_idx[i] != i) begin
        bad++; $display("FAIL %s_entry%0d got=%h@%0d exp=%h@%0d", tag, i, q_data[i], q_idx[i], exp_q[i], i);
      end
    end
    total++; if (!done_seen || done_gap != 1) begin
      bad++; $display("FAIL %s_done_timing got=seen%0d_gap%0d exp=seen1_gap1", tag, done_seen, done_gap);
    end
    total++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      bad++; $display("FAIL %s_after_done got=done%b_busy%b exp=00", tag, done_after, busy_after);
    end
    total++; if (hold_err != 0) begin
      bad++; $display("FAIL %s_hold got=%0d exp=0", tag, hold_err);
    end
  endtask

  task automatic test_basic();
    clear_opts();
    wr(0, 8'hA5); wr(1, 8'h3C); wr(2, 8'hFF);
    snap_exp(3);
    play(3, 100);
    check_run("basic");
    total++; if (n_busy != 3) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=3", n_busy); end
  endtask

  task automatic test_stall();
    clear_opts();
    wr(0, 8'hA5); wr(1, 8'h3C); wr(2, 8'hFF);
    snap_exp(3);
    stall_idx = 1;
    play(3, 100);
    check_run("stall");
    total++; if (n_busy != 7) begin bad++; $display("FAIL stall_busy_cycles got=%0d exp=7", n_busy); end
  endtask

  task automatic test_zero_and_clip();
    clear_opts();
    snap_exp(0);
    play(0, 100);
    check_run("zero");
    total++; if (n_busy != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", n_busy); end
    for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
    snap_exp(25);
    play(25, 100);
    check_run("clip");
    snap_exp(31);
    play(31, 60);
    check_run("clip_rnd");
  endtask

  task automatic test_forward();
    clear_opts();
    wr(0, 8'h11);
    sw_en = 1; sw_addr = 0; sw_data = 8'h77;
    snap_exp(0); exp_q.push_back(8'h77);
    play(1, 100);
    check_run("fwd");
  endtask

  task automatic test_write_during_play();
    clear_opts();
    for (int i = 0; i < 5; i++) wr(i, 8'($urandom));
    snap_exp(5);
    mw_en = 1; mw_addr = 0; mw_data = ~tbl[0];
    play(5, 100);
    check_run("wr_current");
    for (int k = 0; k < 2; k++) begin
      snap_exp(5);
      mw_addr = (k == 0) ? 1 : 4; mw_data = 8'($urandom);
      exp_q[mw_addr] = mw_data;
      play(5, (k == 0) ? 100 : 50);
      check_run("wr_ahead");
    end
  endtask

  task automatic test_abort();
    int stray;
    clear_opts();
    for (int i = 0; i < 5; i++) wr(i, 8'($urandom));
    snap_exp(5);
    abort_after = 2;
    play(5, 100);
    total++; if (q_data.size() != 2) begin bad++; $display("FAIL abort_xfers got=%0d exp=2", q_data.size()); end
    total++; if (ab_valid !== 1'b0 || ab_busy !== 1'b0 || ab_done !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl got=v%b_b%b_d%b exp=000", ab_valid, ab_busy, ab_done);
    end
    total++; if (ab_index !== 5'd0 || ab_data !== 8'h00) begin
      bad++; $display("FAIL abort_regs got=%0d/%h exp=0/00", ab_index, ab_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    stray = 0;
    repeat (5) begin
      if (o_done || o_out_valid) stray++;
      @(posedge clk); #1;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", stray); end
    abort_after = 0;
    play(5, 100);
    check_run("replay");
  endtask

  task automatic test_oob_write();
    int hits;
    logic [7:0] v;
    clear_opts();
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      if (v == 8'h99) v = 8'h98;
      wr(i, v);
    end
    wr(20, 8'h99);
    snap_exp(20);
    play(20, 70);
    check_run("oob");
    hits = 0;
    foreach (q_data[i]) if (q_data[i] == 8'h99) hits++;
    total++; if (hits != 0) begin bad++; $display("FAIL oob_leak got=%0d exp=0", hits); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_opts();
      repeat ($urandom_range(4)) wr($urandom_range(24), 8'($urandom));
      start_spam = 1'($urandom_range(1));
      sw_en = 1'($urandom_range(1)); sw_addr = $urandom_range(24); sw_data = 8'($urandom);
      if (sw_en && sw_addr < DEPTH) begin
        tbl[sw_addr] = sw_data;
      end
      begin
        int cnt;
        cnt = $urandom_range(31);
        snap_exp(cnt);
        play(cnt, $urandom_range(30, 100));
      end
      check_run("rand");
    end
  endtask

  initial begin
    clear_opts();
    test_reset();
    test_basic();
    test_stall();
    test_zero_and_clip();
    test_forward();
    test_write_during_play();
    test_abort();
    test_oob_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
